// File: rtl/demux1x8_reg.sv
// Registered 1-to-8 demultiplexer: each accepted word is steered by Sel into a
// one-deep per-lane holding register that its consumer drains with Out_ready.
module demux1x8_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   In,
   input  logic               In_valid,
   output logic               In_ready,
   input  logic [2:0]         Sel,
   output logic [8*WIDTH-1:0] Out,
   output logic [7:0]         Out_valid,
   input  logic [7:0]         Out_ready,
   output logic [15:0]        Xfer_count
);

   logic [WIDTH-1:0] r_data [8];
   logic [7:0]       r_full;
   logic [15:0]      r_count;

   logic             w_ready;
   logic             w_accept;
   logic [7:0]       w_load;
   logic [7:0]       w_drain;

   // A full lane can still take a word when its consumer drains it this cycle.
   always_comb begin
      w_ready     = ~r_full[Sel] | Out_ready[Sel];
      w_accept    = In_valid & w_ready;
      w_load      = '0;
      if (w_accept) begin
         w_load[Sel] = 1'b1;
      end
      w_drain     = r_full & Out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 8; i++) begin
            r_data[i] <= '0;
         end
         r_full  <= '0;
         r_count <= '0;
      end else begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (w_load[i]) begin
               r_data[i] <= In;
               r_full[i] <= 1'b1;
            end else if (w_drain[i]) begin
               r_full[i] <= 1'b0;
            end
         end
         if (w_accept) begin
            r_count <= r_count + 16'd1;
         end
      end
   end

   always_comb begin
      Out = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         Out[i*WIDTH +: WIDTH] = r_data[i];
      end
   end

   assign In_ready   = w_ready;
   assign Out_valid  = r_full;
   assign Xfer_count = r_count;

endmodule

// File: tb/tb_demux1x8_reg.sv
// Directed bench for demux1x8_reg: a vector table for reset, fan-out,
// multi-drain and backpressure, plus hand sequences for streaming and wrap.
module tb_demux1x8_reg;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic [W-1:0]   In;
   logic           In_valid;
   logic           In_ready;
   logic [2:0]     Sel;
   logic [8*W-1:0] Out;
   logic [7:0]     Out_valid;
   logic [7:0]     Out_ready;
   logic [15:0]    Xfer_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   demux1x8_reg #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .In         (In),
      .In_valid   (In_valid),
      .In_ready   (In_ready),
      .Sel        (Sel),
      .Out        (Out),
      .Out_valid  (Out_valid),
      .Out_ready  (Out_ready),
      .Xfer_count (Xfer_count)
   );

   typedef struct {
      bit          rst;
      bit          iv;
      logic [2:0]  sel;
      logic [31:0] din;
      logic [7:0]  ordy;
      bit          chk_rdy;
      bit          exp_rdy;
      logic [7:0]  exp_ov;
      logic [15:0] exp_cnt;
      logic [2:0]  chk_lane;
      logic [31:0] exp_lane;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, bit iv, logic [2:0] sel, logic [31:0] din,
                               logic [7:0] ordy, bit chk_rdy, bit exp_rdy,
                               logic [7:0] exp_ov, logic [15:0] exp_cnt,
                               logic [2:0] chk_lane, logic [31:0] exp_lane);
      vec_t v;
      v.rst = r; v.iv = iv; v.sel = sel; v.din = din; v.ordy = ordy;
      v.chk_rdy = chk_rdy; v.exp_rdy = exp_rdy; v.exp_ov = exp_ov;
      v.exp_cnt = exp_cnt; v.chk_lane = chk_lane; v.exp_lane = exp_lane;
      return v;
   endfunction

   function automatic logic [W-1:0] lane(int i);
      return Out[i*W +: W];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit iv, input logic [2:0] sel,
                        input logic [31:0] din, input logic [7:0] ordy);
      rst = r; In_valid = iv; Sel = sel; In = din; Out_ready = ordy;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b1, 1'b0, 3'd0, '0, '0);

      // reset with a valid word presented: nothing may be latched
      tbl.push_back(mk(1, 1, 3'd3, 32'hDEADBEEF, 8'h00, 0, 0, 8'h00, 16'd0, 3'd3, 32'h0));
      tbl.push_back(mk(1, 1, 3'd3, 32'hDEADBEEF, 8'h00, 0, 0, 8'h00, 16'd0, 3'd3, 32'h0));
      // fan-out to all eight lanes
      for (int i = 0; i < 8; i++) begin
         tbl.push_back(mk(0, 1, 3'(i), 32'h100 + 32'(i), 8'h00, 1, 1,
                          8'((16'd1 << (i + 1)) - 16'd1), 16'(i + 1), 3'(i), 32'h100 + 32'(i)));
      end
      // drain everything except lanes 0, 4, 7
      tbl.push_back(mk(0, 0, 3'd0, 32'h0, 8'h6E, 0, 0, 8'h91, 16'd8, 3'd0, 32'h100));
      // multi-drain of 0, 4, 7 while loading lane 1
      tbl.push_back(mk(0, 1, 3'd1, 32'h111, 8'h91, 1, 1, 8'h02, 16'd9, 3'd1, 32'h111));
      // backpressure on lane 5
      tbl.push_back(mk(0, 1, 3'd5, 32'hAAAA, 8'h00, 1, 1, 8'h22, 16'd10, 3'd5, 32'hAAAA));
      tbl.push_back(mk(0, 1, 3'd5, 32'hBBBB, 8'h00, 1, 0, 8'h22, 16'd10, 3'd5, 32'hAAAA));
      tbl.push_back(mk(0, 1, 3'd5, 32'hBBBB, 8'h00, 1, 0, 8'h22, 16'd10, 3'd5, 32'hAAAA));
      tbl.push_back(mk(0, 1, 3'd5, 32'hBBBB, 8'h20, 1, 1, 8'h22, 16'd11, 3'd5, 32'hBBBB));
      // drain lanes 1 and 5, then Out_ready on empty lanes is harmless
      tbl.push_back(mk(0, 0, 3'd5, 32'hCCCC, 8'h22, 0, 0, 8'h00, 16'd11, 3'd5, 32'hBBBB));
      tbl.push_back(mk(0, 0, 3'd2, 32'hDDDD, 8'hFF, 0, 0, 8'h00, 16'd11, 3'd2, 32'h102));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].din, tbl[i].ordy);
         if (tbl[i].chk_rdy)
            check($sformatf("v%0d in_ready", i), 64'(In_ready), 64'(tbl[i].exp_rdy));
         step();
         check($sformatf("v%0d out_valid", i), 64'(Out_valid), 64'(tbl[i].exp_ov));
         check($sformatf("v%0d xfer_count", i), 64'(Xfer_count), 64'(tbl[i].exp_cnt));
         check($sformatf("v%0d lane%0d", i, tbl[i].chk_lane),
               64'(lane(int'(tbl[i].chk_lane))), 64'(tbl[i].exp_lane));
         if (i == 1)
            check("reset out zero", 64'(Out === '0), 64'd1);
         if (i == 9) begin
            for (int l = 0; l < 8; l++) begin
               if (l != 7)
                  check($sformatf("fanout lane%0d", l), 64'(lane(l)), 64'(32'h100 + l));
            end
         end
      end

      // streaming into lane 2 with its consumer always ready
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b1, 3'd2, 32'hC000 + 32'(k), 8'h04);
         check($sformatf("stream%0d in_ready", k), 64'(In_ready), 64'd1);
         step();
         check($sformatf("stream%0d lane2", k), 64'(lane(2)), 64'(32'hC000 + k));
         check($sformatf("stream%0d valid", k), 64'(Out_valid), 64'h04);
      end
      check("stream count", 64'(Xfer_count), 64'd21);
      drive(1'b0, 1'b0, 3'd2, '0, 8'h04);
      step();
      check("stream drained", 64'(Out_valid), 64'h00);

      // counter wrap: reset, 65534 accepts, then two more
      drive(1'b1, 1'b0, 3'd0, '0, 8'h00);
      step();
      check("prewrap reset cnt", 64'(Xfer_count), 64'd0);
      for (int k = 0; k < 65534; k++) begin
         drive(1'b0, 1'b1, 3'(k % 8), 32'(k), 8'hFF);
         step();
      end
      check("preload cnt", 64'(Xfer_count), 64'hFFFE);
      check("preload valid", 64'(Out_valid), 64'h20);
      check("preload lane5", 64'(lane(5)), 64'hFFFD);
      drive(1'b0, 1'b0, 3'd0, '0, 8'hFF);
      step();
      check("idle valid", 64'(Out_valid), 64'h00);
      drive(1'b0, 1'b1, 3'd6, 32'h66, 8'h00);
      step();
      check("cnt ffff", 64'(Xfer_count), 64'hFFFF);
      drive(1'b0, 1'b1, 3'd7, 32'h77, 8'h00);
      step();
      check("cnt wrap", 64'(Xfer_count), 64'h0000);
      check("wrap valid", 64'(Out_valid), 64'hC0);
      check("wrap lane7", 64'(lane(7)), 64'h77);

      // mid-operation reset with lanes full and a valid word presented
      drive(1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 8'h00);
      step();
      check("midrst valid", 64'(Out_valid), 64'h00);
      check("midrst cnt", 64'(Xfer_count), 64'd0);
      check("midrst out zero", 64'(Out === '0), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
